// File: rtl/exe_mem_sched.sv
// exe_mem_sched: pipeline hazard and data-memory scheduler.
// Freezes the whole pipe while the load/store at the EXE/MEM outputs runs a
// req/ack handshake with data memory (with a timeout abort), inserts a
// load-use bubble into ID/EXE, and counts PC-stall cycles (saturating).
module exe_mem_sched #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_mem_ctrl,
    input  logic [15:0] i_exe_ctrl,
    input  logic [3:0]  i_exe_rd,
    input  logic [3:0]  i_id_rs1,
    input  logic [3:0]  i_id_rs2,
    input  logic        i_mem_ack,
    output logic        o_hold_pc,
    output logic        o_hold_if_id,
    output logic        o_hold_id_exe,
    output logic        o_hold_exe_mem,
    output logic        o_hold_mem_wb,
    output logic        o_bubble_id_exe,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_mem_err,
    output logic [15:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Last WAIT cycle count before the access is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_tcnt;
    logic        r_mem_req;
    logic        r_mem_we;
    logic        r_mem_err;
    logic [15:0] r_stall_cnt;

    logic w_mem_op;
    logic w_mem_stall;
    logic w_hazard;
    logic w_timeout;
    logic w_unused_ctrl;

    // Only the low control bits matter to the scheduler.
    assign w_unused_ctrl = ^{i_mem_ctrl[15:2], i_exe_ctrl[15:1]};

    // Stall sources: memory access in progress and load-use hazard.
    always_comb begin
        w_mem_op    = i_mem_ctrl[0] | i_mem_ctrl[1];
        w_mem_stall = ((r_state == ST_IDLE) && w_mem_op) || (r_state == ST_WAIT);
        w_hazard    = i_exe_ctrl[0] && (i_exe_rd != 4'd0) &&
                      ((i_exe_rd == i_id_rs1) || (i_exe_rd == i_id_rs2));
        w_timeout   = (r_tcnt == TMO_LAST);
    end

    // Hold/bubble outputs; memory stall wins over load-use, reset freezes all.
    always_comb begin
        o_hold_pc       = !rst_n || w_mem_stall || w_hazard;
        o_hold_if_id    = !rst_n || w_mem_stall || w_hazard;
        o_hold_id_exe   = !rst_n || w_mem_stall;
        o_hold_exe_mem  = !rst_n || w_mem_stall;
        o_hold_mem_wb   = !rst_n || w_mem_stall;
        o_bubble_id_exe = rst_n && !w_mem_stall && w_hazard;
    end

    // Memory handshake FSM with registered req/we/err and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tcnt    <= '0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_err <= 1'b0;
        end else begin
            r_mem_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_tcnt <= '0;
                    if (w_mem_op) begin
                        r_state   <= ST_WAIT;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= i_mem_ctrl[1];
                    end
                end
                ST_WAIT: begin
                    if (i_mem_ack) begin
                        r_state   <= ST_DONE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end else if (w_timeout) begin
                        r_state   <= ST_DONE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (o_hold_pc && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_err   = r_mem_err;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_exe_mem_sched.sv
// Directed testbench for exe_mem_sched (MEM_TIMEOUT = 4).
// Each row: {ack, mem_ctrl[1:0], exe_mr, exe_rd, rs1, rs2, expected obs}.
// obs = {hold pc,if_id,id_exe,exe_mem,mem_wb, bubble, req, req&we, err}.
module tb_exe_mem_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_mem_ctrl;
    logic [15:0] i_exe_ctrl;
    logic [3:0]  i_exe_rd;
    logic [3:0]  i_id_rs1;
    logic [3:0]  i_id_rs2;
    logic        i_mem_ack;
    logic        o_hold_pc, o_hold_if_id, o_hold_id_exe, o_hold_exe_mem, o_hold_mem_wb;
    logic        o_bubble_id_exe, o_mem_req, o_mem_we, o_mem_err;
    logic [15:0] o_stall_cnt;
    logic [8:0]  obs;

    int checks = 0;
    int errors = 0;

    localparam logic [12:0] NOEXE = 13'd0;
    localparam logic [12:0] HAZ   = {1'b1, 4'd5, 4'd0, 4'd5};

    exe_mem_sched #(.MEM_TIMEOUT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_mem_ctrl     (i_mem_ctrl),
        .i_exe_ctrl     (i_exe_ctrl),
        .i_exe_rd       (i_exe_rd),
        .i_id_rs1       (i_id_rs1),
        .i_id_rs2       (i_id_rs2),
        .i_mem_ack      (i_mem_ack),
        .o_hold_pc      (o_hold_pc),
        .o_hold_if_id   (o_hold_if_id),
        .o_hold_id_exe  (o_hold_id_exe),
        .o_hold_exe_mem (o_hold_exe_mem),
        .o_hold_mem_wb  (o_hold_mem_wb),
        .o_bubble_id_exe(o_bubble_id_exe),
        .o_mem_req      (o_mem_req),
        .o_mem_we       (o_mem_we),
        .o_mem_err      (o_mem_err),
        .o_stall_cnt    (o_stall_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {o_hold_pc, o_hold_if_id, o_hold_id_exe, o_hold_exe_mem, o_hold_mem_wb,
                  o_bubble_id_exe, o_mem_req, o_mem_req & o_mem_we, o_mem_err};

    task automatic drive(input logic [24:0] r);
        i_mem_ack  = r[24];
        i_mem_ctrl = {14'd0, r[23:22]};
        i_exe_ctrl = {15'd0, r[21]};
        i_exe_rd   = r[20:17];
        i_id_rs1   = r[16:13];
        i_id_rs2   = r[12:9];
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(25'd0);
        #12;
        checks++;
        if (obs !== 9'b11111_0_000) begin
            errors++;
            $display("FAIL reset_outputs obs=%b expected=%b", obs, 9'b11111_0_000);
        end
        checks++;
        if (o_stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stall_cnt got=%0d expected=0", o_stall_cnt);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load;
        logic [24:0] tab [5] = '{
            {1'b0, 2'b01, NOEXE, 9'b11111_0_000},
            {1'b0, 2'b01, NOEXE, 9'b11111_0_100},
            {1'b1, 2'b01, NOEXE, 9'b11111_0_100},
            {1'b0, 2'b00, NOEXE, 9'b00000_0_000},
            {1'b0, 2'b00, NOEXE, 9'b00000_0_000}};
        for (int i = 0; i < 5; i++) begin
            drive(tab[i]); #1;
            checks++;
            if (obs !== tab[i][8:0]) begin
                errors++;
                $display("FAIL load cyc%0d obs=%b expected=%b", i, obs, tab[i][8:0]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (o_stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL load_stall_cnt got=%0d expected=3", o_stall_cnt);
        end
    endtask

    task automatic test_store;
        logic [24:0] tab [4] = '{
            {1'b0, 2'b11, NOEXE, 9'b11111_0_000},
            {1'b1, 2'b11, NOEXE, 9'b11111_0_110},
            {1'b0, 2'b00, NOEXE, 9'b00000_0_000},
            {1'b0, 2'b00, NOEXE, 9'b00000_0_000}};
        for (int i = 0; i < 4; i++) begin
            drive(tab[i]); #1;
            checks++;
            if (obs !== tab[i][8:0]) begin
                errors++;
                $display("FAIL store cyc%0d obs=%b expected=%b", i, obs, tab[i][8:0]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (o_stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL store_stall_cnt got=%0d expected=5", o_stall_cnt);
        end
    endtask

    task automatic test_timeout;
        logic [24:0] tab [7] = '{
            {1'b0, 2'b01, NOEXE, 9'b11111_0_000},
            {1'b0, 2'b01, NOEXE, 9'b11111_0_100},
            {1'b0, 2'b01, NOEXE, 9'b11111_0_100},
            {1'b0, 2'b01, NOEXE, 9'b11111_0_100},
            {1'b0, 2'b01, NOEXE, 9'b11111_0_100},
            {1'b0, 2'b00, NOEXE, 9'b00000_0_001},
            {1'b0, 2'b00, NOEXE, 9'b00000_0_000}};
        for (int i = 0; i < 7; i++) begin
            drive(tab[i]); #1;
            checks++;
            if (obs !== tab[i][8:0]) begin
                errors++;
                $display("FAIL timeout cyc%0d obs=%b expected=%b", i, obs, tab[i][8:0]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (o_stall_cnt !== 16'd10) begin
            errors++;
            $display("FAIL timeout_stall_cnt got=%0d expected=10", o_stall_cnt);
        end
    endtask

    task automatic test_ack_at_timeout;
        logic [24:0] tab [7] = '{
            {1'b0, 2'b01, NOEXE, 9'b11111_0_000},
            {1'b0, 2'b01, NOEXE, 9'b11111_0_100},
            {1'b0, 2'b01, NOEXE, 9'b11111_0_100},
            {1'b0, 2'b01, NOEXE, 9'b11111_0_100},
            {1'b1, 2'b01, NOEXE, 9'b11111_0_100},
            {1'b0, 2'b00, NOEXE, 9'b00000_0_000},
            {1'b0, 2'b00, NOEXE, 9'b00000_0_000}};
        for (int i = 0; i < 7; i++) begin
            drive(tab[i]); #1;
            checks++;
            if (obs !== tab[i][8:0]) begin
                errors++;
                $display("FAIL ack_at_timeout cyc%0d obs=%b expected=%b", i, obs, tab[i][8:0]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (o_stall_cnt !== 16'd15) begin
            errors++;
            $display("FAIL ack_at_timeout_stall_cnt got=%0d expected=15", o_stall_cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [24:0] tab [7] = '{
            {1'b0, 2'b01, NOEXE, 9'b11111_0_000},
            {1'b1, 2'b01, NOEXE, 9'b11111_0_100},
            {1'b0, 2'b01, NOEXE, 9'b00000_0_000},
            {1'b0, 2'b01, NOEXE, 9'b11111_0_000},
            {1'b1, 2'b01, NOEXE, 9'b11111_0_100},
            {1'b0, 2'b00, NOEXE, 9'b00000_0_000},
            {1'b0, 2'b00, NOEXE, 9'b00000_0_000}};
        for (int i = 0; i < 7; i++) begin
            drive(tab[i]); #1;
            checks++;
            if (obs !== tab[i][8:0]) begin
                errors++;
                $display("FAIL back_to_back cyc%0d obs=%b expected=%b", i, obs, tab[i][8:0]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (o_stall_cnt !== 16'd19) begin
            errors++;
            $display("FAIL back_to_back_stall_cnt got=%0d expected=19", o_stall_cnt);
        end
    endtask

    task automatic test_load_use;
        logic [24:0] tab [9] = '{
            {1'b0, 2'b00, HAZ,                          9'b11000_1_000},
            {1'b0, 2'b00, {1'b0, 4'd5, 4'd0, 4'd5},     9'b00000_0_000},
            {1'b0, 2'b00, {1'b1, 4'd0, 4'd0, 4'd0},     9'b00000_0_000},
            {1'b0, 2'b00, {1'b1, 4'd5, 4'd5, 4'd3},     9'b11000_1_000},
            {1'b0, 2'b00, {1'b1, 4'd7, 4'd5, 4'd3},     9'b00000_0_000},
            {1'b0, 2'b01, HAZ,                          9'b11111_0_000},
            {1'b1, 2'b01, HAZ,                          9'b11111_0_100},
            {1'b0, 2'b00, HAZ,                          9'b11000_1_000},
            {1'b0, 2'b00, NOEXE,                        9'b00000_0_000}};
        for (int i = 0; i < 9; i++) begin
            drive(tab[i]); #1;
            checks++;
            if (obs !== tab[i][8:0]) begin
                errors++;
                $display("FAIL load_use cyc%0d obs=%b expected=%b", i, obs, tab[i][8:0]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (o_stall_cnt !== 16'd24) begin
            errors++;
            $display("FAIL load_use_stall_cnt got=%0d expected=24", o_stall_cnt);
        end
    endtask

    task automatic test_reset_mid_wait;
        drive({1'b0, 2'b01, NOEXE, 9'd0});
        @(posedge clk); #1;
        checks++;
        if (o_mem_req !== 1'b1) begin
            errors++;
            $display("FAIL midwait_req_before got=%b expected=1", o_mem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({obs, o_stall_cnt} !== {9'b11111_0_000, 16'd0}) begin
            errors++;
            $display("FAIL midwait_reset obs=%b cnt=%0d expected=%b cnt=0",
                     obs, o_stall_cnt, 9'b11111_0_000);
        end
        i_mem_ack  = 1'b1;
        i_mem_ctrl = 16'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        @(posedge clk); #1;
        i_mem_ack = 1'b0;
        checks++;
        if ({obs, o_stall_cnt} !== {9'b00000_0_000, 16'd0}) begin
            errors++;
            $display("FAIL midwait_late_ack obs=%b cnt=%0d expected=000000000 cnt=0",
                     obs, o_stall_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== 9'b00000_0_000) begin
            errors++;
            $display("FAIL midwait_idle obs=%b expected=000000000", obs);
        end
    endtask

    task automatic test_saturate;
        drive({1'b0, 2'b00, {1'b1, 4'd5, 4'd5, 4'd0}, 9'd0});
        repeat (65534) @(posedge clk);
        #1;
        checks++;
        if (o_stall_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pre got=%h expected=fffe", o_stall_cnt);
        end
        repeat (4466) @(posedge clk);
        #1;
        checks++;
        if (o_stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold got=%h expected=ffff", o_stall_cnt);
        end
        drive(25'd0);
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_timeout();
        test_ack_at_timeout();
        test_back_to_back();
        test_load_use();
        test_reset_mid_wait();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
